// File: rtl/iir_biquad_seq.sv
// rtl/iir_biquad_seq.sv - direct-form-II biquad sequencer with shared saturating MAC
module iir_biquad_seq #(
    parameter int N = 20,
    parameter int F = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] Uk_in,
    input  logic [N-1:0] muxS,
    input  logic [N-1:0] muxC,
    input  logic [N-1:0] muxZ,
    output logic [2:0]   controlS,
    output logic [1:0]   controlC,
    output logic [2:0]   controlZ,
    output logic [N-1:0] Uk,
    output logic [N-1:0] fk,
    output logic [N-1:0] fk1,
    output logic [N-1:0] fk2,
    output logic [N-1:0] acum1,
    output logic [N-1:0] acum2,
    output logic [N-1:0] acum3,
    output logic [N-1:0] yk,
    output logic         busy,
    output logic         done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S1   = 3'd1;
    localparam logic [2:0] S2   = 3'd2;
    localparam logic [2:0] S3   = 3'd3;
    localparam logic [2:0] S4   = 3'd4;
    localparam logic [2:0] S5   = 3'd5;
    localparam logic [2:0] UPD  = 3'd6;

    logic [2:0] state;
    logic [2:0] next_state;

    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] prod_sh;
    logic signed [2*N:0]   sum;
    logic        [N-1:0]   mac;

    // Full-width product and sum; only the final result is clamped to N bits.
    always_comb begin
        prod    = $signed(muxS) * $signed(muxC);
        prod_sh = prod >>> F;
        sum     = $signed({{(N+1){muxZ[N-1]}}, muxZ}) + $signed({prod_sh[2*N-1], prod_sh});
        if (sum[2*N:N-1] == {(N+2){sum[2*N]}}) begin
            mac = sum[N-1:0];
        end else if (sum[2*N]) begin
            mac = {1'b1, {(N-1){1'b0}}};
        end else begin
            mac = {1'b0, {(N-1){1'b1}}};
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = start ? S1 : IDLE;
            S1:      next_state = S2;
            S2:      next_state = S3;
            S3:      next_state = S4;
            S4:      next_state = S5;
            S5:      next_state = UPD;
            default: next_state = IDLE;
        endcase
    end

    // {controlS, controlC, controlZ} presented during each step
    function automatic logic [7:0] ctl_of(input logic [2:0] s);
        case (s)
            S1:      ctl_of = 8'b001_01_001;
            S2:      ctl_of = 8'b010_10_011;
            S3:      ctl_of = 8'b011_11_000;
            S4:      ctl_of = 8'b100_01_101;
            S5:      ctl_of = 8'b101_10_011;
            default: ctl_of = 8'b000_00_000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            controlS <= '0;
            controlC <= '0;
            controlZ <= '0;
            Uk       <= '0;
            fk       <= '0;
            fk1      <= '0;
            fk2      <= '0;
            acum1    <= '0;
            acum2    <= '0;
            acum3    <= '0;
            yk       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state                          <= next_state;
            {controlS, controlC, controlZ} <= ctl_of(next_state);
            busy                           <= (next_state != IDLE);
            done                           <= (state == UPD);
            case (state)
                IDLE: if (start) Uk <= Uk_in;
                S1:   acum1 <= mac;
                S2: begin
                    acum2 <= mac;
                    fk    <= mac;
                end
                S3:   acum3 <= mac;
                S4:   acum1 <= mac;
                S5:   yk    <= mac;
                UPD: begin
                    fk2 <= fk1;
                    fk1 <= fk;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// tb/tb_iir_biquad_seq.sv - scoreboard bench for iir_biquad_seq with external mux model
module tb_iir_biquad_seq;
    localparam int N = 20;
    localparam int F = 14;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [N-1:0] Uk_in, muxS, muxC, muxZ;
    logic [2:0]   controlS, controlZ;
    logic [1:0]   controlC;
    logic [N-1:0] Uk, fk, fk1, fk2, acum1, acum2, acum3, yk;
    logic         busy, done;

    always #5 clk = ~clk;

    iir_biquad_seq #(.N(N), .F(F)) dut (
        .clk(clk), .reset(reset), .start(start), .Uk_in(Uk_in),
        .muxS(muxS), .muxC(muxC), .muxZ(muxZ),
        .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
        .Uk(Uk), .fk(fk), .fk1(fk1), .fk2(fk2),
        .acum1(acum1), .acum2(acum2), .acum3(acum3),
        .yk(yk), .busy(busy), .done(done)
    );

    logic signed [N-1:0] a1, a2, b0, b1, b2;

    always_comb begin
        muxS = '0;
        muxC = '0;
        muxZ = '0;
        case (controlS)
            3'b001: muxS = a1;
            3'b010: muxS = a2;
            3'b011: muxS = b0;
            3'b100: muxS = b1;
            3'b101: muxS = b2;
            default: muxS = '0;
        endcase
        case (controlC)
            2'b01: muxC = fk1;
            2'b10: muxC = fk2;
            2'b11: muxC = fk;
            default: muxC = '0;
        endcase
        case (controlZ)
            3'b001: muxZ = Uk;
            3'b010: muxZ = yk;
            3'b011: muxZ = acum1;
            3'b100: muxZ = acum2;
            3'b101: muxZ = acum3;
            default: muxZ = '0;
        endcase
    end

    typedef struct {
        longint y;
        longint f;
    } exp_t;

    exp_t   sb[$];
    int     vectors = 0;
    int     errors  = 0;
    longint m_f1 = 0;
    longint m_f2 = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        longint lim;
        lim = longint'(1) <<< (N-1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic longint mul(input longint c, input longint x);
        return (c * x) >>> F;
    endfunction

    task automatic model_step(input longint u, output longint y, output longint f);
        longint p, a3;
        p  = sat(u + mul(a1, m_f1));
        f  = sat(p + mul(a2, m_f2));
        a3 = sat(mul(b0, f));
        p  = sat(a3 + mul(b1, m_f1));
        y  = sat(p + mul(b2, m_f2));
        m_f2 = m_f1;
        m_f1 = f;
    endtask

    task automatic push_model(input longint u);
        exp_t e;
        model_step(u, e.y, e.f);
        sb.push_back(e);
    endtask

    task automatic push_const(input longint u, input longint ey, input longint ef);
        exp_t e;
        longint dy, df;
        model_step(u, dy, df);
        e.y = ey;
        e.f = ef;
        sb.push_back(e);
    endtask

    task automatic pulse_start(input longint u);
        @(posedge clk); #1;
        start = 1'b1;
        Uk_in = u[N-1:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check("busy_timeout", n, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        m_f1 = 0;
        m_f2 = 0;
    endtask

    task automatic set_default_coeffs();
        a1 = 32112;
        a2 = -15736;
        b0 = 16384;
        b1 = -32768;
        b2 = 16384;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ctl"}, {controlS, controlC, controlZ}, 0);
        check({tag, "_regs"}, longint'(|{Uk, fk, fk1, fk2, acum1, acum2, acum3, yk}), 0);
    endtask

    task automatic impulse_run();
        push_const(16384, 16384, 16384);
        pulse_start(16384);
        wait_done();
        push_const(0, -656, 32112);
        pulse_start(0);
        wait_done();
        push_const(0, -638, 47202);
        pulse_start(0);
        wait_done();
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("yk", longint'($signed(yk)), e.y);
                check("fk", longint'($signed(fk)), e.f);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] trace [0:6];
        logic signed [15:0] r16;
        logic signed [N-1:0] rn;
        int n;
        trace[0] = 8'b001_01_001;
        trace[1] = 8'b010_10_011;
        trace[2] = 8'b011_11_000;
        trace[3] = 8'b100_01_101;
        trace[4] = 8'b101_10_011;
        trace[5] = 8'b000_00_000;
        trace[6] = 8'b000_00_000;

        set_default_coeffs();
        reset = 1'b1;
        start = 1'b0;
        Uk_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        impulse_run();

        // control trace on one sample, then a start in the done cycle
        push_model(1234);
        pulse_start(1234);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("ctl_step%0d", i), {controlS, controlC, controlZ}, trace[i]);
            check($sformatf("done_step%0d", i), done, (i == 6) ? 1 : 0);
            check($sformatf("busy_step%0d", i), busy, (i < 6) ? 1 : 0);
        end
        push_model(-5000);
        start = 1'b1;
        Uk_in = 20'hFEC78;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("b2b_gap", n, 7);

        // start during S3 must be ignored
        push_model(7777);
        pulse_start(7777);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        Uk_in = 20'd99999;
        @(posedge clk); #1;
        start = 1'b0;
        check("uk_hold", longint'(Uk), 7777);
        wait_done();
        repeat (3) @(negedge clk);

        // reset during S4
        do_reset();
        push_model(16384);
        pulse_start(16384);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_f1 = 0;
        m_f2 = 0;
        @(negedge clk);
        check_all_zero("midreset");
        repeat (10) @(negedge clk);
        impulse_run();

        // saturation, both polarities
        do_reset();
        push_model(524287);
        pulse_start(524287);
        wait_done();
        check("sat_pos_fk1", longint'($signed(fk)), 524287);
        push_model(524287);
        pulse_start(524287);
        wait_done();
        check("sat_pos_fk2", longint'($signed(fk)), 524287);
        do_reset();
        push_model(-524288);
        pulse_start(-524288);
        wait_done();
        push_model(-524288);
        pulse_start(-524288);
        wait_done();
        check("sat_neg_fk2", longint'($signed(fk)), -524288);

        // randomized coefficients and samples
        for (int b = 0; b < 4; b++) begin
            do_reset();
            r16 = 16'($urandom); a1 = r16;
            r16 = 16'($urandom); a2 = r16;
            r16 = 16'($urandom); b0 = r16;
            r16 = 16'($urandom); b1 = r16;
            r16 = 16'($urandom); b2 = r16;
            for (int k = 0; k < 6; k++) begin
                rn = N'($urandom);
                if (k % 2 == 1) rn = rn >>> 6;
                push_model(longint'(rn));
                pulse_start(longint'(rn));
                wait_done();
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
